// File: rtl/seq_div_pkg.sv
// Shared widths and FSM state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_N = 8;
    localparam int DIV_M = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle between a divider client (master) and seq_div (slave).
interface seq_div_if
    import div_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) ();

    logic         i_start;
    logic [N-1:0] i_dividend;
    logic [M-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_quotient;
    logic [M-1:0] o_remainder;
    logic         o_div_by_zero;

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
    );

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
    );

endinterface

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int M = 4
) (
    input  logic [M:0]   i_r,
    input  logic         i_qMsb,
    input  logic [M-1:0] i_d,
    output logic [M:0]   o_r,
    output logic         o_qBit
);

    logic [M:0] w_t;

    assign w_t = {i_r[M-1:0], i_qMsb};

    // A set top bit in r means the shifted value certainly exceeds d.
    always_comb begin
        o_r    = w_t;
        o_qBit = 1'b0;
        if (i_r[M] || (w_t >= {1'b0, i_d})) begin
            o_r    = w_t - {1'b0, i_d};
            o_qBit = 1'b1;
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, registered results with a done pulse.
module seq_div
    import div_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input logic        clk,
    input logic        rst,
    seq_div_if.slave   bus
);

    localparam int CW = $clog2(N + 1);

    state_t       r_state;
    state_t       w_stateNext;
    logic [N-1:0] r_q;
    logic [M-1:0] r_d;
    logic [M:0]   r_r;
    logic [CW-1:0] r_count;
    logic [N-1:0] r_quotient;
    logic [M-1:0] r_remainder;
    logic         r_divZero;

    logic         w_accept;
    logic         w_zeroDivisor;
    logic         w_lastStep;
    logic [M:0]   w_rNext;
    logic         w_qBit;
    logic [N-1:0] w_qNext;

    div_step #(.M(M)) u_step (
        .i_r    (r_r),
        .i_qMsb (r_q[N-1]),
        .i_d    (r_d),
        .o_r    (w_rNext),
        .o_qBit (w_qBit)
    );

    assign w_qNext = {r_q[N-2:0], w_qBit};

    // DONE also accepts a new request so back-to-back operation loses no cycle.
    always_comb begin
        w_stateNext   = r_state;
        w_zeroDivisor = (bus.i_divisor == '0);
        w_accept      = bus.i_start && (r_state != CALC);
        w_lastStep    = (r_state == CALC) && (r_count == CW'(1));
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_stateNext = w_zeroDivisor ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_lastStep) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (bus.i_start) begin
                    w_stateNext = w_zeroDivisor ? DONE : CALC;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divZero   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_q       <= bus.i_dividend;
                r_d       <= bus.i_divisor;
                r_r       <= '0;
                r_count   <= CW'(N);
                r_divZero <= w_zeroDivisor;
                if (w_zeroDivisor) begin
                    r_quotient  <= '1;
                    r_remainder <= '0;
                end
            end else if (r_state == CALC) begin
                r_q     <= w_qNext;
                r_r     <= w_rNext;
                r_count <= r_count - CW'(1);
                if (w_lastStep) begin
                    r_quotient  <= w_qNext;
                    r_remainder <= w_rNext[M-1:0];
                end
            end
        end
    end

    assign bus.o_busy        = (r_state == CALC);
    assign bus.o_done        = (r_state == DONE);
    assign bus.o_quotient    = r_quotient;
    assign bus.o_remainder   = r_remainder;
    assign bus.o_div_by_zero = r_divZero;

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: expected results come from integer / and % at start time.
module tb_seq_div;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } res_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    res_t sb[$];

    seq_div_if #(.N(8), .M(4)) bus ();

    seq_div #(.N(8), .M(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [7:0] a, input logic [3:0] b);
        res_t e;
        if (b == 4'd0) begin
            e = {8'hFF, 4'h0, 1'b1};
        end else begin
            e.q  = 8'(a / b);
            e.r  = 4'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Called at a negedge: start is seen by the following posedge, cleared at the next negedge.
    task automatic drive_start(input logic [7:0] a, input logic [3:0] b);
        bus.i_start    = 1'b1;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic get_result(input int lat0, output int lat, output bit seen,
                              output res_t expv, output res_t obs);
        lat = lat0;
        while (bus.o_done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        seen = (bus.o_done === 1'b1);
        obs  = {bus.o_quotient, bus.o_remainder, bus.o_div_by_zero};
        if (sb.size() > 0) expv = sb.pop_front();
        else               expv = '1;
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        repeat (2) @(negedge clk);
        outs = {bus.o_busy, bus.o_done, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero};
        total++;
        if (outs !== 15'd0) begin
            bad++;
            $display("[TB] FAIL reset_state got=%h want=%h", outs, 15'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.o_busy, bus.o_done} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL idle_after_reset got=%b want=00", {bus.o_busy, bus.o_done});
        end
    endtask

    task automatic run_table(input string name, input logic [7:0] as[3], input logic [3:0] bs[3]);
        int   lat;
        bit   seen;
        res_t e, o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_start(as[i], bs[i]);
            get_result(1, lat, seen, e, o);
            total++;
            if (!seen || lat != 9) begin
                bad++;
                $display("[TB] FAIL %s_latency[%0d] got=%0d seen=%0b want=9", name, i, lat, seen);
            end
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL %s_result[%0d] got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         name, i, o.q, o.r, o.dz, e.q, e.r, e.dz);
            end
            @(negedge clk);
            total++;
            if (bus.o_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s_done_pulse[%0d] got=%b want=0", name, i, bus.o_done);
            end
        end
    endtask

    task automatic test_products();
        logic [7:0] as[3];
        logic [3:0] bs[3];
        as = '{8'h0C, 8'h79, 8'hC3};
        bs = '{4'h4, 4'hB, 4'hD};
        run_table("product", as, bs);
    endtask

    task automatic test_remainder();
        logic [7:0] as[3];
        logic [3:0] bs[3];
        as = '{8'h37, 8'hFF, 8'h05};
        bs = '{4'h4, 4'h1, 4'h9};
        run_table("remainder", as, bs);
    endtask

    task automatic test_div_zero();
        int   lat;
        bit   seen;
        bit   busySeen;
        res_t e, o;
        @(negedge clk);
        drive_start(8'h5A, 4'h0);
        busySeen = (bus.o_busy !== 1'b0);
        get_result(1, lat, seen, e, o);
        total++;
        if (!seen || lat != 1) begin
            bad++;
            $display("[TB] FAIL div0_latency got=%0d seen=%0b want=1", lat, seen);
        end
        total++;
        if (o !== e) begin
            bad++;
            $display("[TB] FAIL div0_result got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     o.q, o.r, o.dz, e.q, e.r, e.dz);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.o_busy !== 1'b0) busySeen = 1'b1;
        end
        total++;
        if (busySeen) begin
            bad++;
            $display("[TB] FAIL div0_busy got=1 want=0");
        end
        total++;
        if ({bus.o_quotient, bus.o_div_by_zero} !== {8'hFF, 1'b1}) begin
            bad++;
            $display("[TB] FAIL div0_hold got q=%h dz=%b want q=ff dz=1",
                     bus.o_quotient, bus.o_div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int   lat;
        bit   seen;
        bit   extra;
        res_t e, o;
        @(negedge clk);
        drive_start(8'h79, 4'hB);
        lat = 1;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        bus.i_start    = 1'b1;
        bus.i_dividend = 8'h37;
        bus.i_divisor  = 4'h4;
        @(negedge clk);
        lat++;
        bus.i_start = 1'b0;
        get_result(lat, lat, seen, e, o);
        total++;
        if (!seen || lat != 9) begin
            bad++;
            $display("[TB] FAIL ignore_latency got=%0d seen=%0b want=9", lat, seen);
        end
        total++;
        if (o !== e) begin
            bad++;
            $display("[TB] FAIL ignore_result got q=%h r=%h want q=%h r=%h", o.q, o.r, e.q, e.r);
        end
        extra = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_done !== 1'b0) extra = 1'b1;
        end
        total++;
        if (extra) begin
            bad++;
            $display("[TB] FAIL ignore_extra_done got=1 want=0");
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   seen;
        res_t e, o;
        @(negedge clk);
        drive_start(8'h0C, 4'h4);
        get_result(1, lat, seen, e, o);
        total++;
        if (!seen || o !== e) begin
            bad++;
            $display("[TB] FAIL b2b_first got q=%h r=%h seen=%0b want q=%h r=%h", o.q, o.r, seen, e.q, e.r);
        end
        drive_start(8'hC3, 4'hD);
        get_result(1, lat, seen, e, o);
        total++;
        if (!seen || lat != 9) begin
            bad++;
            $display("[TB] FAIL b2b_latency got=%0d seen=%0b want=9", lat, seen);
        end
        total++;
        if (o !== e) begin
            bad++;
            $display("[TB] FAIL b2b_second got q=%h r=%h want q=%h r=%h", o.q, o.r, e.q, e.r);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        bit          seen;
        bit          extra;
        res_t        e, o;
        logic [14:0] outs;
        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_dividend = 8'h37;
        bus.i_divisor  = 4'h4;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        outs = {bus.o_busy, bus.o_done, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero};
        total++;
        if (outs !== 15'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_outputs got=%h want=%h", outs, 15'd0);
        end
        @(negedge clk);
        rst   = 1'b0;
        extra = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_done !== 1'b0) extra = 1'b1;
        end
        total++;
        if (extra) begin
            bad++;
            $display("[TB] FAIL reset_mid_done got=1 want=0");
        end
        drive_start(8'hFF, 4'hF);
        get_result(1, lat, seen, e, o);
        total++;
        if (!seen || lat != 9 || o !== e) begin
            bad++;
            $display("[TB] FAIL after_reset got q=%h r=%h lat=%0d want q=%h r=%h lat=9",
                     o.q, o.r, lat, e.q, e.r);
        end
    endtask

    task automatic test_random_sweep();
        int         lat;
        bit         seen;
        res_t       e, o;
        logic [7:0] a;
        logic [3:0] b;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 4'($urandom_range(0, 15));
            @(negedge clk);
            drive_start(a, b);
            get_result(1, lat, seen, e, o);
            total++;
            if (!seen || o !== e) begin
                bad++;
                $display("[TB] FAIL sweep[%0d] %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         i, a, b, o.q, o.r, o.dz, e.q, e.r, e.dz);
            end
            if (b != 4'd0) begin
                total++;
                if ((32'(o.q) * 32'(b) + 32'(o.r) != 32'(a)) || (o.r >= b)) begin
                    bad++;
                    $display("[TB] FAIL sweep_invariant[%0d] %h/%h got q=%h r=%h", i, a, b, o.q, o.r);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_products();
        test_remainder();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential restoring divider: the inverse companion of the 4x4 array multiplier, recovering a factor from an 8-bit product. Accepts an N-bit dividend and an M-bit divisor on a start pulse and iterates one quotient bit per clock. Returns the quotient and remainder with a one-cycle done pulse. Used to check multiplier products by round trip, and wherever the datapath needs integer division without a combinational array.

## Interface
- N, 8: dividend and quotient width.
- M, 4: divisor and remainder width; M <= N.
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- dividend  in  N  unsigned dividend, sampled with start.
- divisor  in  M  unsigned divisor, sampled with start.
- busy  out  1  high while iterating (CALC state).
- done  out  1  one-cycle pulse; results valid in this cycle.
- quotient  out  N  unsigned quotient.
- remainder  out  M  unsigned remainder.
- div_by_zero  out  1  set with done when divisor was 0.

## Operation
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - On start=1, latch dividend into shift register q and divisor into d.
  - Clear partial remainder r (M+1 bits) and load count=N.
  - If the divisor is nonzero, go to CALC; if it is 0, go to DONE with div_by_zero flagged.
- CALC, one step per cycle:
  - t = {r[M-1:0], q[N-1]}; q <= {q[N-2:0], 0}.
  - If t >= {0,d}: r <= t - d and q[0] <= 1. Otherwise r <= t.
  - Decrement count. When it reaches 0 (after N steps), go to DONE.
- DONE, exactly one cycle:
  - Assert done. quotient = q, remainder = r[M-1:0].
  - Next state is IDLE, or CALC if start=1 in this cycle (back-to-back accept).
- Divide by zero:
  - quotient = all ones, remainder = 0, div_by_zero = 1.
  - No CALC cycles are spent.
- Result registers hold their values after done until the next result overwrites them. div_by_zero holds until the next accepted start.
- Invariant for nonzero divisor: dividend = quotient*divisor + remainder, remainder < divisor.
- Dividend < divisor gives quotient 0, remainder = dividend.
- start while busy=1 is ignored. Operands are not re-sampled.
- All arithmetic is unsigned. r needs M+1 bits to hold t before subtraction.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers=0.
- Reset mid-CALC aborts the operation. No done is produced for the aborted request.
- start is sampled at edge k:
  - Nonzero divisor: busy=1 after edges k..k+N-1, done=1 after edge k+N. Latency is N+1 cycles, start to done.
  - Divisor 0: done=1 after edge k, with busy never asserted. Latency is 1 cycle.
- Throughput with back-to-back starts held in DONE: one result per N+1 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package div_pkg holds the default N and M and the state enum (IDLE, CALC, DONE).
- One natural sub-module, div_step: a purely combinational single restoring step.
  - Inputs r, q MSB and d.
  - Outputs next r and the quotient bit.
  - Instanced once inside the FSM.

## Test plan
- Round trip of multiplier products: 0x0C/0x4 -> q=0x03 r=0x0; 0x79/0xB -> q=0x0B r=0x0; 0xC3/0xD -> q=0x0F r=0x0. Each done arrives exactly 9 cycles after start.
- Remainder and small cases: 0x37/0x4 -> q=0x0D r=0x3; 0xFF/0x1 -> q=0xFF r=0x0; 0x05/0x9 -> q=0x00 r=0x5.
- Divide by zero: 0x5A/0x0 -> done one cycle after start, q=0xFF, r=0x0, div_by_zero=1, busy stays 0.
- start pulsed mid-CALC with new operands -> ignored; the original result is delivered. Back-to-back start in the DONE cycle -> second done exactly 9 cycles later.
- rst asserted at cycle 4 of CALC -> all outputs 0 immediately, no done pulse. A following 0xFF/0xF -> q=0x11 r=0x0.
- Random sweep over all 8-bit dividends and 4-bit divisors -> invariant holds on every done pulse.
